// File: rtl/seg7_scan_decoder.sv
// Recovers per-position hex digits from a multiplexed active-low 7-segment scan.
// Define SEG7_STABLE_FILTER_EN to require STABLE identical samples before a commit.
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   blank,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err
);

`ifdef SEG7_STABLE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  localparam logic [3:0] STAB = FILTER_EN ? 4'(STABLE) : 4'd1;

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [6:0]          seg_s_q, run_seg_q;
  logic [NDIG-1:0]     an_s_q, run_an_q;
  logic [4*NDIG-1:0]   digits_q;
  logic [NDIG-1:0]     blank_q;
  logic                upd_q, err_q;
  logic [2:0]          idx_q;
  logic                valid, same, commit;
  logic [2:0]          sel;
  logic [5:0]          dec;

  // {decodable, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {2'b10, 4'h0};
      7'b1111001: decode = {2'b10, 4'h1};
      7'b0100100: decode = {2'b10, 4'h2};
      7'b0110000: decode = {2'b10, 4'h3};
      7'b0011001: decode = {2'b10, 4'h4};
      7'b0010010: decode = {2'b10, 4'h5};
      7'b0000010: decode = {2'b10, 4'h6};
      7'b1111000: decode = {2'b10, 4'h7};
      7'b0000000: decode = {2'b10, 4'h8};
      7'b0010000: decode = {2'b10, 4'h9};
      7'b0001000: decode = {2'b10, 4'hA};
      7'b0000011: decode = {2'b10, 4'hB};
      7'b1000110: decode = {2'b10, 4'hC};
      7'b0100001: decode = {2'b10, 4'hD};
      7'b0000110: decode = {2'b10, 4'hE};
      7'b0001110: decode = {2'b10, 4'hF};
      7'b1111111: decode = {2'b11, 4'h0};
      default:    decode = 6'b000000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!clrn) begin
      seg_s_q <= '1;
      an_s_q  <= '1;
    end else begin
      seg_s_q <= seg_n;
      an_s_q  <= an_n;
    end
  end

  always_comb begin
    valid = $onehot(~an_s_q);
    same  = ({an_s_q, seg_s_q} == {run_an_q, run_seg_q});
    dec   = decode(seg_s_q);
    sel   = 3'd0;
    for (int i = 0; i < NDIG; i++)
      if (!an_s_q[i]) sel = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:
        if (valid) begin
          state_d = TRACK;
          cnt_d   = 4'd1;
        end
      TRACK:
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (same) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd1;
        end
      DONE:
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (!same) begin
          state_d = TRACK;
          cnt_d   = 4'd1;
        end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Reaching the threshold commits on the same edge; DONE then blocks re-commit.
    if (state_d == TRACK && cnt_d == STAB) begin
      commit  = 1'b1;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      run_seg_q <= '1;
      run_an_q  <= '1;
      digits_q  <= '0;
      blank_q   <= '1;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      if (valid) begin
        run_seg_q <= seg_s_q;
        run_an_q  <= an_s_q;
      end
      if (commit) begin
        if (dec[5]) begin
          upd_q <= 1'b1;
          idx_q <= sel;
          for (int i = 0; i < NDIG; i++) begin
            if (3'(i) == sel) begin
              blank_q[i] <= dec[4];
              if (!dec[4]) digits_q[4*i +: 4] <= dec[3:0];
            end
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign digits  = digits_q;
  assign blank   = blank_q;
  assign upd     = upd_q;
  assign upd_idx = idx_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed, table-driven bench for seg7_scan_decoder (NDIG=4, STABLE=3).
module tb_seg7_scan_decoder;

`ifdef SEG7_STABLE_FILTER_EN
  localparam int S = 3;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;

  int total = 0;
  int passed = 0;
  int n_upd, n_err, n_both;

  seg7_scan_decoder #(.NDIG(4), .STABLE(3)) dut (
    .clk(clk), .clrn(clrn), .seg_n(seg_n), .an_n(an_n),
    .digits(digits), .blank(blank), .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          exp_upd;
    int          exp_err;
    logic [15:0] exp_dig;
    logic [3:0]  exp_blank;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t       vt[11];
  logic [6:0] code[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (upd) n_upd++;
    if (err) n_err++;
    if (upd && err) n_both++;
  endtask

  task automatic clear_counts();
    n_upd = 0; n_err = 0; n_both = 0;
  endtask

  task automatic idle_flush();
    an_n = 4'hF; seg_n = 7'h7F;
    repeat (8) step();
  endtask

  task automatic do_reset();
    an_n = 4'hF; seg_n = 7'h7F;
    clrn = 1'b0;
    step();
    clrn = 1'b1;
  endtask

  // Counts edges until upd rises; -1 if it never does.
  task automatic wait_upd(output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (upd) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    clear_counts();
    an_n = v.an; seg_n = v.seg;
    repeat (v.hold) step();
    idle_flush();
    chk({name, " upd count"}, 32'(n_upd), 32'(v.exp_upd));
    chk({name, " err count"}, 32'(n_err), 32'(v.exp_err));
    chk({name, " upd&err"}, 32'(n_both), 32'd0);
    chk({name, " digits"}, 32'(digits), 32'(v.exp_dig));
    chk({name, " blank"}, 32'(blank), 32'(v.exp_blank));
    chk({name, " upd_idx"}, 32'(upd_idx), 32'(v.exp_idx));
  endtask

  initial begin
    int lat;
    code = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    vt[0]  = '{4'hE, 7'b0110000, 3, 1, 0, 16'h0003, 4'b1110, 3'd0};
    vt[1]  = '{4'hE, 7'b1111001, 5, 1, 0, 16'h0001, 4'b1110, 3'd0};
    vt[2]  = '{4'hD, 7'b0001000, 5, 1, 0, 16'h00A1, 4'b1100, 3'd1};
    vt[3]  = '{4'hB, 7'b0001110, 5, 1, 0, 16'h0FA1, 4'b1000, 3'd2};
    vt[4]  = '{4'h7, 7'b1000000, 5, 1, 0, 16'h0FA1, 4'b0000, 3'd3};
    vt[5]  = '{4'hD, 7'b1111111, 3, 1, 0, 16'h0FA1, 4'b0010, 3'd1};
    vt[6]  = '{4'hE, 7'b1010101, 3, 0, 1, 16'h0FA1, 4'b0010, 3'd1};
    vt[7]  = '{4'hC, 7'b0000000, 5, 0, 0, 16'h0FA1, 4'b0010, 3'd1};
    vt[8]  = '{4'hB, 7'b0000010, 4, 1, 0, 16'h06A1, 4'b0010, 3'd2};
    vt[9]  = '{4'h7, 7'b0000110, 4, 1, 0, 16'hE6A1, 4'b0010, 3'd3};
    vt[10] = '{4'hD, 7'b0100001, 4, 1, 0, 16'hE6D1, 4'b0000, 3'd1};

    clear_counts();
    repeat (2) step();
    do_reset();
    chk("reset digits", 32'(digits), 32'h0);
    chk("reset blank", 32'(blank), 32'hF);
    chk("reset upd", 32'(upd), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset upd_idx", 32'(upd_idx), 32'h0);

    // Commit latency from the first stable input cycle.
    an_n = 4'hE; seg_n = 7'b0110000;
    wait_upd(lat);
    chk("latency", 32'(lat), 32'(S + 1));
    chk("latency digit", 32'(digits[3:0]), 32'h3);
    step();
    chk("upd one cycle", 32'(upd), 32'h0);
    idle_flush();

    do_reset();
    for (int i = 0; i < 11; i++) apply(vt[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      logic [3:0] nib;
      nib = 4'(i);
      v = '{4'h7, code[i], 4, 1, 0, {nib, 12'h6D1}, 4'b0000, 3'd3};
      apply(v, $sformatf("code%0d", i));
    end

    // Pattern changing every 2 cycles never settles under the filter.
    clear_counts();
    for (int k = 0; k < 12; k++) begin
      an_n = 4'hE;
      seg_n = ((k / 2) % 2 == 0) ? 7'b0100100 : 7'b0011001;
      step();
    end
    idle_flush();
    chk("glitch upd count", 32'(n_upd), 32'((S == 1) ? 6 : 0));
    chk("glitch err count", 32'(n_err), 32'd0);

    // Reset on the 2nd cycle of a stable run discards it.
    an_n = 4'hE; seg_n = 7'b0010010;
    step();
    step();
    clrn = 1'b0;
    step();
    chk("midrst digits", 32'(digits), 32'h0);
    chk("midrst blank", 32'(blank), 32'hF);
    chk("midrst upd", 32'(upd), 32'h0);
    chk("midrst err", 32'(err), 32'h0);
    chk("midrst upd_idx", 32'(upd_idx), 32'h0);
    clrn = 1'b1;
    wait_upd(lat);
    chk("midrst latency", 32'(lat), 32'(S + 1));
    chk("midrst digit", 32'(digits), 32'h0005);
    chk("midrst blank after", 32'(blank), 32'hE);
    idle_flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
